// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter that owns an internal N:1 bit-mux. One requester at a
// time is granted the mux for a tenure of up to MAX_BEATS beats. The selected
// input bit is registered together with a valid flag, so downstream logic gets
// a clean serial stream qualified by ownership.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous reset, active-high, overrides everything else
//   req      request vector, req[i] = requester i wants the mux
//   I        mux data inputs, I[i] belongs to requester i
//   gnt      registered one-hot grant, zero when idle
//   sel      registered index of the current owner, drives the mux
//   busy     registered, high while a grant is active
//   y        registered mux output, I[sel] captured on a beat
//   y_valid  registered, high for one cycle after each beat
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BEATS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         I,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] sel,
    output logic                 busy,
    output logic                 y,
    output logic                 y_valid
);

    localparam int SEL_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N-1:0]     gnt_nxt;
    logic             busy_nxt;
    logic             y_nxt;
    logic             y_valid_nxt;

    logic             beat_p0;
    logic             last_p0;
    logic             rls_p0;
    logic [SEL_W:0]   search_p0;
    logic             found_p0;
    logic [SEL_W-1:0] winner_p0;

    // First set bit of cand scanning upward from (from+1) mod N with wrap.
    // The loop runs from the farthest offset down to the nearest, so the
    // nearest set bit is the one left in res. Offset N is 'from' itself and
    // therefore has the lowest priority. MSB of the result flags a hit.
    function automatic logic [SEL_W:0] rr_search(
        input logic [N-1:0]     cand,
        input logic [SEL_W-1:0] from
    );
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = N; k >= 1; k--) begin
            idx = SEL_W'((int'(from) + k) % N);
            if (cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Stage p0: beat/release decode and round-robin search on live req
    always_comb begin
        beat_p0 = (state == GRANT) && req[sel];
        last_p0 = beat_p0 && (cnt == CNT_LAST);
        rls_p0  = (state == GRANT) && (!req[sel] || last_p0);

        // In GRANT the pointer is about to become sel, so search from sel
        // directly to avoid a one-cycle lag on handoff.
        search_p0 = rr_search(req, (state == GRANT) ? sel : ptr);
        found_p0  = search_p0[SEL_W];
        winner_p0 = search_p0[SEL_W-1:0];

        state_nxt   = state;
        ptr_nxt     = ptr;
        sel_nxt     = sel;
        cnt_nxt     = cnt;
        gnt_nxt     = gnt;
        busy_nxt    = busy;
        y_valid_nxt = beat_p0;
        y_nxt       = beat_p0 ? I[sel] : y;

        case (state)
            IDLE: begin
                if (found_p0) begin
                    state_nxt          = GRANT;
                    gnt_nxt            = '0;
                    gnt_nxt[winner_p0] = 1'b1;
                    sel_nxt            = winner_p0;
                    busy_nxt           = 1'b1;
                    cnt_nxt            = '0;
                end
            end
            GRANT: begin
                if (rls_p0) begin
                    ptr_nxt = sel;
                    if (found_p0) begin
                        // Direct handoff, or re-grant of a sole requester.
                        gnt_nxt            = '0;
                        gnt_nxt[winner_p0] = 1'b1;
                        sel_nxt            = winner_p0;
                        cnt_nxt            = '0;
                    end else begin
                        // sel deliberately holds its last value.
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        busy_nxt  = 1'b0;
                    end
                end else if (beat_p0) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // Stage p1: registered grant state and mux output
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= PTR_RST;
            sel     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            sel     <= sel_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            busy    <= busy_nxt;
            y       <= y_nxt;
            y_valid <= y_valid_nxt;
        end
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one N:1 bit-mux among N requesters. It drives the mux select and keeps a grant for a bounded burst of beats. It registers the selected bit with a valid flag so the downstream logic sees a clean, ownership-qualified serial stream. The N:1 mux itself is built inside the block: y is I[sel], registered.

Parameters:
N, 4, number of requesters and mux inputs; legal range N >= 2.
MAX_BEATS, 8, maximum beats per grant tenure; legal range MAX_BEATS >= 1. MAX_BEATS=1 gives per-beat round robin.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
req  input  N  request vector; req[i]=1 means requester i wants the mux
I  input  N  data inputs; I[i] belongs to requester i
gnt  output  N  one-hot grant, registered; all zeros when idle
sel  output  $clog2(N)  registered index of the current owner; drives the mux
busy  output  1  registered; 1 while a grant is active
y  output  1  registered mux output, I[sel] captured on a beat
y_valid  output  1  registered; 1 for exactly one cycle after each beat

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. rst takes priority over all other activity.
- Reset values: gnt=0, sel=0, busy=0, y=0, y_valid=0, state=IDLE, beat counter cnt=0, last-owner pointer ptr=N-1. Because ptr=N-1, the first search after reset starts at index 0.
- Internal state: FSM with two states, IDLE and GRANT.
- cnt width is $clog2(MAX_BEATS+1). It counts the beats completed in the current tenure.
- Search function: find the first set bit of the candidate vector, scanning upward from index (ptr+1) mod N and wrapping past N-1 to 0.
- IDLE:
  - If req==0, stay in IDLE; outputs keep their idle values.
  - If req!=0, at the next edge: winner w from the search; gnt=one-hot(w), sel=w, busy=1, cnt=0, go to GRANT.
  - First grant latency: one cycle from req being sampled.
- GRANT, beat definition: a beat is any cycle in GRANT where req[sel]=1.
- GRANT, output register on each edge:
  - y_valid <= beat.
  - y <= I[sel] on a beat; otherwise y holds its value.
  - Net effect: y/y_valid lag the beat by 1 cycle.
- GRANT, on a beat with cnt < MAX_BEATS-1: cnt <= cnt+1; grant is held.
- GRANT, release occurs when either:
  - (a) req[sel]=0, which is an early release and counts as no beat; or
  - (b) a beat occurs with cnt == MAX_BEATS-1, which is the last beat.
- At the release edge:
  - ptr <= sel.
  - Re-search the current req from (sel+1) mod N. The owner's own bit is reached last, so it has lowest priority.
  - If a winner exists: hand off directly with no idle bubble. Set gnt/sel to the winner, cnt=0, stay in GRANT.
  - A sole requester that hits MAX_BEATS is re-granted in the same edge: gnt is unchanged and cnt=0.
  - If no winner: go to IDLE with gnt=0, busy=0. sel holds its last value.
- Simultaneous events: requests that arrive during a tenure have no effect until the release edge. Requests that drop before the release edge are not considered in the search.
- Invariants:
  - gnt is always one-hot or zero.
  - busy == (gnt != 0).
  - When busy=1, gnt[sel]=1.
- Reset mid-tenure: at the next edge all outputs and ptr return to their reset values. Any in-flight y_valid is cleared.

Test Plan:
- Post-reset first grant (N=4): hold rst=1 for 2 cycles with req=1111 -> gnt=0000, busy=0, y_valid=0. Then release rst -> after 1 edge gnt=0001, sel=0, busy=1.
- Sole requester at the burst limit (MAX_BEATS=8): hold req=0100 with I[2] toggling each cycle -> gnt=0100 stays continuously with no bubble, cnt wraps every 8 beats, y_valid stays 1, and y equals I[2] delayed by 1 cycle.
- Full-load rotation (MAX_BEATS=2): hold req=1111 -> sel sequence 0,0,1,1,2,2,3,3,0,0 and gnt follows one-hot.
- Early release with handoff: owner 1 and req[3]=1. Drop req[1] after 3 beats -> next edge gnt=1000 with no idle cycle. y_valid is low for exactly 1 cycle.
- Fairness after idle: last owner=2, then req=0000 -> IDLE with gnt=0, busy=0. Then req=0101 -> grant index 0, because the search starts at 3.
- Reset mid-tenure: assert rst during owner 3, beat 4 -> next edge gnt=0, busy=0, y=0, y_valid=0. With req=1010 after reset -> grant index 1.
